// File: rtl/man_encoder.sv
// Manchester line encoder: takes a word over valid/ready and sends sync, MSB-first bits and an idle gap.
// Define MAN_ENC_PARITY_EN to append an even-parity Manchester bit after the data.
module man_encoder #(
  parameter int HALF_BIT = 4,
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              out,
  output logic              busy
);

  localparam int HCNT_W = (HALF_BIT > 2) ? $clog2(HALF_BIT) : 1;
  localparam int BCNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC_LO,
    S_SYNC_HI,
    S_DATA,
`ifdef MAN_ENC_PARITY_EN
    S_PARITY,
`endif
    S_GAP
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [HCNT_W-1:0]   r_hcnt;
  logic                r_half;
  logic [BCNT_W-1:0]   r_bcnt;
  logic [DATA_W-1:0]   r_shreg;
  logic                r_out;
  logic                w_out_nxt;
  logic                w_xfer;
  logic                w_half_end;
  logic                w_bit_end;
  logic                w_gap_end;
`ifdef MAN_ENC_PARITY_EN
  logic                r_par;
`endif

  assign w_xfer     = din_valid && (r_state == S_IDLE);
  assign w_half_end = (r_hcnt == HCNT_W'(HALF_BIT - 1));
  assign w_bit_end  = w_half_end && r_half;
  // The gap is one clock short in-state; the IDLE cycle that follows supplies its last high clock.
  assign w_gap_end  = r_half && (r_hcnt == HCNT_W'(HALF_BIT - 2));

  assign din_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out       = r_out;

  always_comb begin
    w_state_nxt = r_state;
    w_out_nxt   = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        if (din_valid) w_state_nxt = S_SYNC_LO;
      end
      S_SYNC_LO: begin
        w_out_nxt = 1'b0;
        if (w_bit_end) w_state_nxt = S_SYNC_HI;
      end
      S_SYNC_HI: begin
        if (w_bit_end) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        // A '1' is low then high; a '0' is high then low.
        w_out_nxt = r_half ? r_shreg[DATA_W-1] : ~r_shreg[DATA_W-1];
        if (w_bit_end && (r_bcnt == '0)) begin
`ifdef MAN_ENC_PARITY_EN
          w_state_nxt = S_PARITY;
`else
          w_state_nxt = S_GAP;
`endif
        end
      end
`ifdef MAN_ENC_PARITY_EN
      S_PARITY: begin
        w_out_nxt = r_half ? r_par : ~r_par;
        if (w_bit_end) w_state_nxt = S_GAP;
      end
`endif
      S_GAP: begin
        if (w_gap_end) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_out   <= 1'b1;
      r_hcnt  <= '0;
      r_half  <= 1'b0;
      r_bcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_out   <= w_out_nxt;
      if ((r_state == S_IDLE) || (w_state_nxt != r_state)) begin
        r_hcnt <= '0;
        r_half <= 1'b0;
      end else if (w_half_end) begin
        r_hcnt <= '0;
        r_half <= ~r_half;
      end else begin
        r_hcnt <= r_hcnt + 1'b1;
      end
      if (w_xfer) begin
        r_bcnt <= BCNT_W'(DATA_W - 1);
      end else if ((r_state == S_DATA) && w_bit_end && (r_bcnt != '0)) begin
        r_bcnt <= r_bcnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_xfer) begin
      r_shreg <= din;
    end else if ((r_state == S_DATA) && w_bit_end) begin
      r_shreg <= r_shreg << 1;
    end
  end

`ifdef MAN_ENC_PARITY_EN
  always_ff @(posedge clk) begin
    if (w_xfer) r_par <= ^din;
  end
`endif

endmodule

// File: tb/tb_man_encoder.sv
// Bench for man_encoder: a line-level scoreboard predicts every out sample from each accepted word.
module tb_man_encoder;

  localparam int H  = 4;
  localparam int DW = 8;
`ifdef MAN_ENC_PARITY_EN
  localparam int PAR_CLKS = 2 * H;
`else
  localparam int PAR_CLKS = 0;
`endif
  localparam int FRAME = 4 * H + 2 * H * DW + PAR_CLKS + 2 * H;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] din;
  logic          din_valid;
  logic          din_ready;
  logic          out;
  logic          busy;

  logic exp_q[$];
  int   n_vec = 0;
  int   n_mis = 0;

  man_encoder #(.HALF_BIT(H), .DATA_W(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .din_valid(din_valid),
    .din_ready(din_ready),
    .out      (out),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Line value after each edge, starting with the transfer edge itself.
  task automatic push_frame(input logic [DW-1:0] w);
    logic b;
    exp_q.push_back(1'b1);
    for (int i = 0; i < 2 * H; i++) exp_q.push_back(1'b0);
    for (int i = 0; i < 2 * H; i++) exp_q.push_back(1'b1);
    for (int k = DW - 1; k >= 0; k--) begin
      b = w[k];
      for (int i = 0; i < H; i++) exp_q.push_back(~b);
      for (int i = 0; i < H; i++) exp_q.push_back(b);
    end
`ifdef MAN_ENC_PARITY_EN
    b = ^w;
    for (int i = 0; i < H; i++) exp_q.push_back(~b);
    for (int i = 0; i < H; i++) exp_q.push_back(b);
`endif
    for (int i = 0; i < 2 * H - 1; i++) exp_q.push_back(1'b1);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!din_ready && n < 300) begin
      step();
      n++;
    end
    check("ready_wait", din_ready, 1'b1);
  endtask

  // Offers a word, lets it transfer on the next edge, then withdraws din_valid.
  task automatic send(input logic [DW-1:0] w);
    din       = w;
    din_valid = 1'b1;
    wait_ready();
    step();
    check("xfer_busy", busy, 1'b1);
    check("xfer_ready", din_ready, 1'b0);
    push_frame(w);
    din_valid = 1'b0;
  endtask

  task automatic wait_end(input int done);
    for (int i = done; i < FRAME - 1; i++) begin
      step();
      if (i == FRAME - 3) check("busy_tail", busy, 1'b1);
    end
    check("end_busy", busy, 1'b0);
    check("end_ready", din_ready, 1'b1);
  endtask

  initial begin
    int cnt;
    rst       = 1'b0;
    din       = 8'hA5;
    din_valid = 1'b1;

    fork
      forever begin
        logic e;
        @(negedge clk);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b1;
        check("line", out, e);
      end
    join_none

    // Reset held with a word on offer: nothing may start.
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_out", out, 1'b1);
      check("rst_busy", busy, 1'b0);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rel_ready", din_ready, 1'b1);
    send(8'hA5);
    wait_end(0);

    // Back-to-back with din_valid held high.
    din       = 8'hFF;
    din_valid = 1'b1;
    wait_ready();
    step();
    push_frame(8'hFF);
    din = 8'h00;
    cnt = 0;
    while (!din_ready && cnt < 300) begin
      step();
      cnt++;
    end
    check_int("ready_gap", cnt, FRAME - 1);
    step();
    cnt++;
    check_int("b2b_period", cnt, FRAME);
    check("b2b_ready_1cyc", din_ready, 1'b0);
    push_frame(8'h00);
    din_valid = 1'b0;
    wait_end(0);

    // Asynchronous reset in the middle of data bit 4.
    send(8'h5A);
    repeat (2 * H + 2 * H + 2 * H * 4 + H - 1) @(posedge clk);
    #3;
    exp_q.delete();
    rst = 1'b0;
    #1;
    check("async_out", out, 1'b1);
    check("async_busy", busy, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    send(8'hC3);
    wait_end(0);

    // din and din_valid wiggle while busy; the latched word must go out.
    send(8'h3C);
    din = 8'hFF;
    repeat (20) step();
    din_valid = 1'b1;
    din       = 8'h81;
    repeat (10) step();
    din_valid = 1'b0;
    wait_end(30);
    repeat (6) begin
      step();
      check("idle_busy", busy, 1'b0);
    end

`ifdef MAN_ENC_PARITY_EN
    send(8'h07);
    wait_end(0);
    send(8'h03);
    wait_end(0);
`endif

    repeat (4) step();
    check_int("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
